mips_multicycle_controller: RTL and testbench

Control unit for the multi-cycle MIPS core. It steps each instruction through fetch, decode, execute, memory and write-back states. Each instruction shares one memory port and one ALU across several cycles. The block drives every datapath mux select and write enable from its state and from the opcode and funct fields held in the instruction register. It also emits a retire pulse and counts retired instructions for the testbench.

---
 rtl/mips_mc_pkg.sv | 81 ++++++++
 rtl/mips_multicycle_controller_alu_control.sv | 21 ++
 rtl/mips_multicycle_controller.sv | 160 ++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: encodings, state enum, control bundle and opcode decode for the multi-cycle MIPS controller
package mips_mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_R_EXEC,
    S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_en;
    logic [1:0] pc_src;
    logic       done;
    logic       illegal;
  } ctrl_t;

  // S_FETCH out of DECODE marks an unsupported opcode/funct
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEM_ADDR;
      OP_RTYPE: s = (fn == FN_JR) ? S_JR :
                    (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) ? S_R_EXEC : S_FETCH;
      OP_ADDI, OP_SLTI, OP_ANDI: s = S_I_EXEC;
      OP_BEQ: s = S_BRANCH;
      OP_J: s = S_JUMP;
      OP_JAL: s = S_JAL;
      default: s = S_FETCH;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/mips_multicycle_controller_alu_control.sv
// mips_alu_control: maps FSM ALUOp plus funct/opcode to the ALU operation code
module mips_alu_control
  import mips_mc_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_operation
);
  logic [2:0] w_funct_op;
  logic [2:0] w_imm_op;
  assign w_funct_op = (i_func == FN_SUB) ? ALU_SUB :
                      (i_func == FN_AND) ? ALU_AND :
                      (i_func == FN_OR)  ? ALU_OR  :
                      (i_func == FN_SLT) ? ALU_SLT : ALU_ADD;
  assign w_imm_op = (i_opcode == OP_SLTI) ? ALU_SLT :
                    (i_opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
  assign o_alu_operation = (i_alu_op == ALUOP_SUB)   ? ALU_SUB    :
                           (i_alu_op == ALUOP_FUNCT) ? w_funct_op :
                           (i_alu_op == ALUOP_IMM)   ? w_imm_op   : ALU_ADD;
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM sequencing the shared-memory, shared-ALU MIPS datapath
module mips_multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  output logic             pcEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOperation,
  output logic [1:0]       PCSrc,
  output logic             instrDone,
  output logic             illegal,
  output logic [CNT_W-1:0] instrCount
);
  state_t           r_state;
  state_t           w_next;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic [2:0]       w_alu_operation;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= r_count + CNT_W'(w_out.done);
    end

  always_comb begin
    w_ctrl = '0;
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_en    = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_BR;
        w_ctrl.alu_en    = 1'b1;
        w_next = decode_next(opcode, func);
        w_ctrl.illegal = (w_next == S_FETCH);
      end
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_en    = 1'b1;
        w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = M2R_MDR;
        w_ctrl.done       = 1'b1;
      end
      S_MEM_WRITE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
        w_ctrl.done      = 1'b1;
      end
      S_R_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_ctrl.alu_en    = 1'b1;
        w_next = S_R_WB;
      end
      S_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = REGDST_RD;
        w_ctrl.done      = 1'b1;
      end
      S_I_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_IMM;
        w_ctrl.alu_en    = 1'b1;
        w_next = S_I_WB;
      end
      S_I_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.done      = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.alu_en        = 1'b1;
        w_ctrl.pc_src        = PCSRC_ALUOUT;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.done          = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_src   = PCSRC_JUMP;
        w_ctrl.pc_write = 1'b1;
        w_ctrl.done     = 1'b1;
      end
      S_JAL: begin
        w_ctrl.pc_src     = PCSRC_JUMP;
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REGDST_RA;
        w_ctrl.mem_to_reg = M2R_PC;
        w_ctrl.done       = 1'b1;
      end
      S_JR: begin
        w_ctrl.pc_src   = PCSRC_REG;
        w_ctrl.pc_write = 1'b1;
        w_ctrl.done     = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // reset forces every output low even though the state already sits at FETCH
  assign w_out = rst ? w_ctrl : '0;

  mips_alu_control u_alu_control (
    .i_alu_op        (w_out.alu_op),
    .i_opcode        (opcode),
    .i_func          (func),
    .o_alu_operation (w_alu_operation)
  );

  assign pcEn         = w_out.pc_write | (w_out.pc_write_cond & zero);
  assign IorD         = w_out.iord;
  assign MemRead      = w_out.mem_read;
  assign MemWrite     = w_out.mem_write;
  assign IRWrite      = w_out.ir_write;
  assign RegWrite     = w_out.reg_write;
  assign RegDst       = w_out.reg_dst;
  assign MemToReg     = w_out.mem_to_reg;
  assign ALUSrcA      = w_out.alu_src_a;
  assign ALUSrcB      = w_out.alu_src_b;
  assign ALUOperation = w_out.alu_en ? w_alu_operation : 3'b000;
  assign PCSrc        = w_out.pc_src;
  assign instrDone    = w_out.done;
  assign illegal      = w_out.illegal;
  assign instrCount   = r_count;
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed per-cycle checks of the controller outputs against hand-built vectors
module tb_mips_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func = 6'd0;
  logic        zero = 1'b0;
  logic        pcEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, instrDone, illegal;
  logic [1:0]  RegDst, MemToReg, ALUSrcB, PCSrc;
  logic [2:0]  ALUOperation;
  logic [15:0] instrCount;
  logic        s_pcEn, s_IorD, s_MemRead, s_MemWrite, s_IRWrite, s_RegWrite, s_ALUSrcA, s_instrDone, s_illegal;
  logic [1:0]  s_RegDst, s_MemToReg, s_ALUSrcB, s_PCSrc;
  logic [2:0]  s_ALUOperation;
  logic [3:0]  s_instrCount;
  logic [19:0] obs, obs2;
  int n_cmp = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [19:0] E_FETCH, E_DEC, E_DEC_IL, E_MADDR, E_MREAD, E_MWB, E_MWR, E_RWB, E_IWB, E_J, E_JAL, E_JR;

  always #5 clk = ~clk;

  mips_multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .pcEn(pcEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation), .PCSrc(PCSrc), .instrDone(instrDone),
    .illegal(illegal), .instrCount(instrCount)
  );

  mips_multicycle_controller #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .pcEn(s_pcEn), .IorD(s_IorD), .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
    .RegWrite(s_RegWrite), .RegDst(s_RegDst), .MemToReg(s_MemToReg), .ALUSrcA(s_ALUSrcA),
    .ALUSrcB(s_ALUSrcB), .ALUOperation(s_ALUOperation), .PCSrc(s_PCSrc), .instrDone(s_instrDone),
    .illegal(s_illegal), .instrCount(s_instrCount)
  );

  assign obs  = {pcEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
                 ALUSrcA, ALUSrcB, ALUOperation, PCSrc, instrDone, illegal};
  assign obs2 = {s_pcEn, s_IorD, s_MemRead, s_MemWrite, s_IRWrite, s_RegWrite, s_RegDst, s_MemToReg,
                 s_ALUSrcA, s_ALUSrcB, s_ALUOperation, s_PCSrc, s_instrDone, s_illegal};

  function automatic logic [19:0] pk(input int pc, iord, mr, mw, irw, rw, rd, m2r, sa, sb, aop, ps, dn, il);
    return {1'(pc), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rw), 2'(rd), 2'(m2r),
            1'(sa), 2'(sb), 3'(aop), 2'(ps), 1'(dn), 1'(il)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; opcode = 6'b100011; zero = 1'b1;
    step(); step();
    n_cmp++; if (obs !== 20'h0) begin n_fail++; $display("FAIL reset_outputs obs=%05h exp=%05h", obs, 20'h0); end
    n_cmp++; if (instrCount !== 16'd0) begin n_fail++; $display("FAIL reset_count obs=%0d exp=0", instrCount); end
    rst = 1'b1; zero = 1'b0;
    #1;
    n_cmp++; if (obs !== E_FETCH) begin n_fail++; $display("FAIL reset_release obs=%05h exp=%05h", obs, E_FETCH); end
  endtask

  task automatic test_rtype();
    logic [19:0] e [4];
    e = '{E_FETCH, E_DEC, pk(0,0,0,0,0,0,0,0,1,0,3'b010,0,0,0), E_RWB};
    opcode = 6'b000000; func = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs !== e[i]) begin n_fail++; $display("FAIL rtype_add cyc%0d obs=%05h exp=%05h", i, obs, e[i]); end
      step();
    end
    exp_cnt++;
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rtype_count obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_lw_sw();
    logic [19:0] e_lw [5];
    logic [19:0] e_sw [4];
    e_lw = '{E_FETCH, E_DEC, E_MADDR, E_MREAD, E_MWB};
    e_sw = '{E_FETCH, E_DEC, E_MADDR, E_MWR};
    opcode = 6'b100011; func = 6'b101010;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (obs !== e_lw[i]) begin n_fail++; $display("FAIL lw cyc%0d obs=%05h exp=%05h", i, obs, e_lw[i]); end
      step();
    end
    opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs !== e_sw[i]) begin n_fail++; $display("FAIL sw cyc%0d obs=%05h exp=%05h", i, obs, e_sw[i]); end
      step();
    end
    exp_cnt += 2;
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL lw_sw_count obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_alu_ops();
    logic [5:0] ops [7] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001010, 6'b001100};
    logic [5:0] fns [7] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000000, 6'b000000};
    logic [2:0] aop [7] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b111, 3'b000};
    logic [19:0] e [4];
    for (int k = 0; k < 7; k++) begin
      opcode = ops[k]; func = fns[k];
      e = (k < 4) ? '{E_FETCH, E_DEC, pk(0,0,0,0,0,0,0,0,1,0,aop[k],0,0,0), E_RWB}
                  : '{E_FETCH, E_DEC, pk(0,0,0,0,0,0,0,0,1,2,aop[k],0,0,0), E_IWB};
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (obs !== e[i]) begin n_fail++; $display("FAIL alu_op%0d cyc%0d obs=%05h exp=%05h", k, i, obs, e[i]); end
        step();
      end
    end
    exp_cnt += 7;
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL alu_ops_count obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_branch();
    logic [19:0] e [3];
    opcode = 6'b000100; func = 6'b000000;
    for (int z = 1; z >= 0; z--) begin
      zero = 1'(z);
      e = '{E_FETCH, E_DEC, pk(z,0,0,0,0,0,0,0,1,0,3'b110,1,1,0)};
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (obs !== e[i]) begin n_fail++; $display("FAIL beq_z%0d cyc%0d obs=%05h exp=%05h", z, i, obs, e[i]); end
        step();
      end
    end
    zero = 1'b0;
    exp_cnt += 2;
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL beq_count obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_jumps();
    logic [5:0] ops [3] = '{6'b000011, 6'b000000, 6'b000010};
    logic [19:0] last [3];
    last = '{E_JAL, E_JR, E_J};
    func = 6'b001000;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs !== ((i == 0) ? E_FETCH : (i == 1) ? E_DEC : last[k])) begin
          n_fail++; $display("FAIL jump%0d cyc%0d obs=%05h", k, i, obs);
        end
        step();
      end
    end
    exp_cnt += 3;
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL jumps_count obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'b111111, 6'b000000};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; func = 6'b000000;
      n_cmp++; if (obs !== E_FETCH) begin n_fail++; $display("FAIL illegal%0d fetch obs=%05h exp=%05h", k, obs, E_FETCH); end
      step();
      n_cmp++; if (obs !== E_DEC_IL) begin n_fail++; $display("FAIL illegal%0d decode obs=%05h exp=%05h", k, obs, E_DEC_IL); end
      step();
    end
    n_cmp++; if (obs !== E_FETCH) begin n_fail++; $display("FAIL illegal_refetch obs=%05h exp=%05h", obs, E_FETCH); end
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL illegal_count obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_fetch_ignore();
    opcode = 6'b111111;
    n_cmp++; if (obs !== E_FETCH) begin n_fail++; $display("FAIL ignore_fetch obs=%05h exp=%05h", obs, E_FETCH); end
    step();
    opcode = 6'b000010;
    #1;
    n_cmp++; if (obs !== E_DEC) begin n_fail++; $display("FAIL ignore_decode obs=%05h exp=%05h", obs, E_DEC); end
    step();
    n_cmp++; if (obs !== E_J) begin n_fail++; $display("FAIL ignore_jump obs=%05h exp=%05h", obs, E_J); end
    step();
    exp_cnt++;
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ignore_count obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] e [4];
    e = '{E_FETCH, E_DEC, E_MADDR, E_MREAD};
    opcode = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs !== e[i]) begin n_fail++; $display("FAIL midrst_lw cyc%0d obs=%05h exp=%05h", i, obs, e[i]); end
      if (i < 3) step();
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (obs !== 20'h0) begin n_fail++; $display("FAIL midrst_outputs obs=%05h exp=%05h", obs, 20'h0); end
    n_cmp++; if (instrCount !== 16'd0) begin n_fail++; $display("FAIL midrst_count obs=%0d exp=0", instrCount); end
    step(); step();
    rst = 1'b1; exp_cnt = 0; opcode = 6'b000010;
    #1;
    n_cmp++; if (obs !== E_FETCH) begin n_fail++; $display("FAIL midrst_restart obs=%05h exp=%05h", obs, E_FETCH); end
    step();
    n_cmp++; if (obs !== E_DEC) begin n_fail++; $display("FAIL midrst_decode obs=%05h exp=%05h", obs, E_DEC); end
    step();
    n_cmp++; if (obs !== E_J) begin n_fail++; $display("FAIL midrst_jump obs=%05h exp=%05h", obs, E_J); end
    step();
    exp_cnt = 1;
    n_cmp++; if (instrCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL midrst_after obs=%0d exp=%0d", instrCount, exp_cnt); end
  endtask

  task automatic test_wrap();
    rst = 1'b0;
    step();
    rst = 1'b1; opcode = 6'b000010;
    #1;
    repeat (15) begin step(); step(); step(); end
    n_cmp++; if (s_instrCount !== 4'hf) begin n_fail++; $display("FAIL wrap_allones obs=%0d exp=15", s_instrCount); end
    step(); step(); step();
    n_cmp++; if (s_instrCount !== 4'h0) begin n_fail++; $display("FAIL wrap_zero obs=%0d exp=0", s_instrCount); end
    n_cmp++; if (instrCount !== 16'd16) begin n_fail++; $display("FAIL wrap_main obs=%0d exp=16", instrCount); end
    n_cmp++; if (obs2 !== E_FETCH) begin n_fail++; $display("FAIL wrap_outputs obs=%05h exp=%05h", obs2, E_FETCH); end
  endtask

  initial begin
    E_FETCH  = pk(1,0,1,0,1,0,0,0,0,1,3'b010,0,0,0);
    E_DEC    = pk(0,0,0,0,0,0,0,0,0,3,3'b010,0,0,0);
    E_DEC_IL = pk(0,0,0,0,0,0,0,0,0,3,3'b010,0,0,1);
    E_MADDR  = pk(0,0,0,0,0,0,0,0,1,2,3'b010,0,0,0);
    E_MREAD  = pk(0,1,1,0,0,0,0,0,0,0,0,0,0,0);
    E_MWB    = pk(0,0,0,0,0,1,0,1,0,0,0,0,1,0);
    E_MWR    = pk(0,1,0,1,0,0,0,0,0,0,0,0,1,0);
    E_RWB    = pk(0,0,0,0,0,1,1,0,0,0,0,0,1,0);
    E_IWB    = pk(0,0,0,0,0,1,0,0,0,0,0,0,1,0);
    E_J      = pk(1,0,0,0,0,0,0,0,0,0,0,2,1,0);
    E_JAL    = pk(1,0,0,0,0,1,2,2,0,0,0,2,1,0);
    E_JR     = pk(1,0,0,0,0,0,0,0,0,0,0,3,1,0);
    test_reset();
    test_rtype();
    test_lw_sw();
    test_alu_ops();
    test_branch();
    test_jumps();
    test_illegal();
    test_fetch_ignore();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
